// File: rtl/uart_loader.sv
// Boot loader fed by the UART receiver: parses SYNC/LEN/data/CSUM frames, streams 16-bit
// words into program memory, and releases the CPU only after a frame's checksum matches.
module uart_loader #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              cpu_run_o,
  output logic              done_o,
  output logic              err_o,
  output logic [8:0]        words_loaded_o,
  output logic [2:0]        state_dbg_o
);

  localparam int              TMR_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CSUM = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        n_q, n_d;
  logic [8:0]        words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              run_q, run_d;
  logic              timeout_s;
  logic              byte_s;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= 9'd0;
      words_q <= 9'd0;
      addr_q  <= '0;
      csum_q  <= 8'd0;
      wdata_q <= 16'd0;
      timer_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  // Next-state, timeout and frame parsing; a timeout swallows a coincident byte
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    words_d   = words_q;
    addr_d    = addr_q;
    csum_d    = csum_q;
    wdata_d   = wdata_q;
    timer_d   = timer_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    run_d     = run_q;
    timeout_s = (state_q != S_IDLE) && (timer_q == TMR_MAX);
    byte_s    = rx_valid_i && !timeout_s;

    // Address/count advance once the write strobe has been presented
    if (we_q) begin
      addr_d  = addr_q + ADDR_W'(1);
      words_d = words_q + 9'd1;
    end else begin
      addr_d  = addr_q;
      words_d = words_q;
    end

    if (state_q == S_IDLE) begin
      timer_d = '0;
    end else if (timeout_s) begin
      timer_d = '0;
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else if (rx_valid_i) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (byte_s && (rx_data_i == SYNC_BYTE)) begin
          state_d = S_LEN;
          run_d   = 1'b0;
          words_d = 9'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (byte_s) begin
          n_d     = (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
          addr_d  = '0;
          csum_d  = 8'd0;
          state_d = S_HI;
        end else begin
          n_d = n_q;
        end
      end
      S_HI: begin
        if (byte_s) begin
          wdata_d[15:8] = rx_data_i;
          csum_d        = csum_q ^ rx_data_i;
          state_d       = S_LO;
        end else begin
          csum_d = csum_q;
        end
      end
      S_LO: begin
        if (byte_s) begin
          wdata_d[7:0] = rx_data_i;
          csum_d       = csum_q ^ rx_data_i;
          we_d         = 1'b1;
          state_d      = ((words_q + 9'd1) == n_q) ? S_CSUM : S_HI;
        end else begin
          csum_d = csum_q;
        end
      end
      S_CSUM: begin
        if (byte_s) begin
          if (rx_data_i == csum_q) begin
            done_d = 1'b1;
            run_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          csum_d = csum_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign cpu_run_o      = run_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;
  assign state_dbg_o    = state_q;

endmodule
